// File: rtl/pipe_skid_reg.sv
// Two-entry skid register: 1-cycle latency, in-order delivery, synchronous flush with saturating drop count.
// Backpressure: in_ready is registered (occupancy != 2); the skid entry absorbs the word in flight while ready drops.
module pipe_skid_reg #(
    parameter int                 DATA_W    = 64,
    parameter logic [DATA_W-1:0]  NOP_VALUE = {DATA_W{1'b0}},
    parameter int                 CNT_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              stall,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  flush_drops
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_in_ready;
    logic [DATA_W-1:0]   r_main;
    logic [DATA_W-1:0]   r_skid;
    logic [CNT_W-1:0]    r_drops;

    logic                w_out_vld;
    logic                w_acc;
    logic                w_pop;
    logic [DATA_W-1:0]   w_main_nxt;
    logic [DATA_W-1:0]   w_skid_nxt;
    logic [1:0]          w_occ;
    logic [CNT_W:0]      w_drops_sum;
    logic [CNT_W-1:0]    w_drops_nxt;

    assign w_occ     = r_state;
    assign w_out_vld = (r_state != ST_EMPTY);
    assign w_acc     = in_valid & r_in_ready;
    assign w_pop     = w_out_vld & out_ready & ~stall;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_FULL);
        end
    end

    // Next-state logic; flush overrides accept, pop and stall
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_acc) w_state_nxt = ST_ONE;
                ST_ONE: begin
                    if (w_acc && !w_pop)      w_state_nxt = ST_FULL;
                    else if (!w_acc && w_pop) w_state_nxt = ST_EMPTY;
                end
                ST_FULL:  if (w_pop) w_state_nxt = ST_ONE;
                default:  w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Output logic
    always_comb begin
        out_valid   = w_out_vld;
        in_ready    = r_in_ready;
        out_data    = r_main;
        occupancy   = w_occ;
        flush_drops = r_drops;
    end

    // Datapath next values follow the same transitions as the state machine
    always_comb begin
        w_main_nxt = r_main;
        w_skid_nxt = r_skid;
        if (flush) begin
            w_main_nxt = NOP_VALUE;
            w_skid_nxt = NOP_VALUE;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_acc) w_main_nxt = in_data;
                ST_ONE: begin
                    if (w_acc && w_pop)       w_main_nxt = in_data;
                    else if (w_acc)           w_skid_nxt = in_data;
                    else if (w_pop)           w_main_nxt = NOP_VALUE;
                end
                ST_FULL: begin
                    if (w_pop) begin
                        w_main_nxt = r_skid;
                        w_skid_nxt = NOP_VALUE;
                    end
                end
                default: begin
                    w_main_nxt = NOP_VALUE;
                    w_skid_nxt = NOP_VALUE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main <= NOP_VALUE;
            r_skid <= NOP_VALUE;
        end else begin
            r_main <= w_main_nxt;
            r_skid <= w_skid_nxt;
        end
    end

    // One extra bit catches overflow; the added occupancy is at most 2, so any carry means saturate
    always_comb begin
        w_drops_sum = {1'b0, r_drops} + (CNT_W+1)'(w_occ);
        w_drops_nxt = w_drops_sum[CNT_W] ? {CNT_W{1'b1}} : w_drops_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drops <= '0;
        end else if (flush) begin
            r_drops <= w_drops_nxt;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed vector table for pipe_skid_reg plus hand sequences for reset and registered-ready corners.
module tb_pipe_skid_reg;

    localparam int               DW  = 16;
    localparam int               CW  = 2;
    localparam logic [DW-1:0]    NOP = 16'hBEEF;

    logic           clk;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  in_data;
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  out_data;
    logic           stall;
    logic           flush;
    logic [1:0]     occupancy;
    logic [CW-1:0]  flush_drops;

    int n_chk  = 0;
    int n_fail = 0;

    pipe_skid_reg #(.DATA_W(DW), .NOP_VALUE(NOP), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall(stall), .flush(flush),
        .occupancy(occupancy), .flush_drops(flush_drops)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic          iv;
        logic [DW-1:0] id;
        logic          ordy;
        logic          stl;
        logic          fl;
        logic [1:0]    occ;
        logic          ir;
        logic [DW-1:0] od;
        logic [CW-1:0] drops;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic iv, logic [DW-1:0] id, logic ordy, logic stl, logic fl,
                                logic [1:0] occ, logic ir, logic [DW-1:0] od, logic [CW-1:0] drops);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy; v.stl = stl; v.fl = fl;
        v.occ = occ; v.ir = ir; v.od = od; v.drops = drops;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [1:0] occ, input logic ir,
                              input logic [DW-1:0] od, input logic [CW-1:0] drops);
        chk({tag, ".occupancy"},   32'(occupancy),   32'(occ));
        chk({tag, ".out_valid"},   32'(out_valid),   32'(occ != 2'd0));
        chk({tag, ".in_ready"},    32'(in_ready),    32'(ir));
        chk({tag, ".out_data"},    32'(out_data),    32'(od));
        chk({tag, ".flush_drops"}, 32'(flush_drops), 32'(drops));
    endtask

    task automatic drive(input logic iv, input logic [DW-1:0] id, input logic ordy,
                         input logic stl, input logic fl);
        in_valid = iv; in_data = id; out_ready = ordy; stall = stl; flush = fl;
    endtask

    initial begin
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #2;
        check_outs("reset", 2'd0, 1'b1, NOP, 2'd0);
        @(negedge clk);
        reset = 1'b0;

        //          iv   id        ordy stl  fl     occ  ir   od        drops
        // stream A,B,C
        tbl.push_back(mk(1, 16'h000A, 1, 0, 0,  2'd1, 1, 16'h000A, 2'd0));
        tbl.push_back(mk(1, 16'h000B, 1, 0, 0,  2'd1, 1, 16'h000B, 2'd0));
        tbl.push_back(mk(1, 16'h000C, 1, 0, 0,  2'd1, 1, 16'h000C, 2'd0));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 0,  2'd0, 1, NOP,      2'd0));
        // backpressure: C offered while full is ignored
        tbl.push_back(mk(1, 16'h000A, 0, 0, 0,  2'd1, 1, 16'h000A, 2'd0));
        tbl.push_back(mk(1, 16'h000B, 0, 0, 0,  2'd2, 0, 16'h000A, 2'd0));
        tbl.push_back(mk(1, 16'h000C, 0, 0, 0,  2'd2, 0, 16'h000A, 2'd0));
        tbl.push_back(mk(1, 16'h000C, 1, 0, 0,  2'd1, 1, 16'h000B, 2'd0));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 0,  2'd0, 1, NOP,      2'd0));
        // stall holds A for 3 cycles, then pops
        tbl.push_back(mk(1, 16'h000A, 0, 0, 0,  2'd1, 1, 16'h000A, 2'd0));
        tbl.push_back(mk(0, 16'h0000, 1, 1, 0,  2'd1, 1, 16'h000A, 2'd0));
        tbl.push_back(mk(0, 16'h0000, 1, 1, 0,  2'd1, 1, 16'h000A, 2'd0));
        tbl.push_back(mk(0, 16'h0000, 1, 1, 0,  2'd1, 1, 16'h000A, 2'd0));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 0,  2'd0, 1, NOP,      2'd0));
        // accepts continue under stall until full
        tbl.push_back(mk(1, 16'h1111, 1, 1, 0,  2'd1, 1, 16'h1111, 2'd0));
        tbl.push_back(mk(1, 16'h2222, 1, 1, 0,  2'd2, 0, 16'h1111, 2'd0));
        tbl.push_back(mk(1, 16'h3333, 1, 1, 0,  2'd2, 0, 16'h1111, 2'd0));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 0,  2'd1, 1, 16'h2222, 2'd0));
        // flush from full with C offered: C discarded, 2 drops
        tbl.push_back(mk(1, 16'h00A0, 0, 0, 0,  2'd2, 0, 16'h2222, 2'd0));
        tbl.push_back(mk(1, 16'h000C, 1, 0, 1,  2'd0, 1, NOP,      2'd2));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 0,  2'd0, 1, NOP,      2'd2));
        // second full flush (with stall) saturates at 3
        tbl.push_back(mk(1, 16'h0011, 0, 0, 0,  2'd1, 1, 16'h0011, 2'd2));
        tbl.push_back(mk(1, 16'h0022, 0, 0, 0,  2'd2, 0, 16'h0011, 2'd2));
        tbl.push_back(mk(1, 16'h0033, 1, 1, 1,  2'd0, 1, NOP,      2'd3));
        tbl.push_back(mk(1, 16'h0033, 0, 0, 0,  2'd1, 1, 16'h0033, 2'd3));
        tbl.push_back(mk(0, 16'h0000, 0, 0, 1,  2'd0, 1, NOP,      2'd3));
        tbl.push_back(mk(0, 16'h0000, 0, 0, 1,  2'd0, 1, NOP,      2'd3));
        // ONE hold with no accept and no pop
        tbl.push_back(mk(1, 16'h0044, 0, 0, 0,  2'd1, 1, 16'h0044, 2'd3));
        tbl.push_back(mk(0, 16'h0000, 0, 0, 0,  2'd1, 1, 16'h0044, 2'd3));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 0,  2'd0, 1, NOP,      2'd3));

        foreach (tbl[i]) begin
            drive(tbl[i].iv, tbl[i].id, tbl[i].ordy, tbl[i].stl, tbl[i].fl);
            @(posedge clk);
            #1;
            check_outs($sformatf("vec%0d", i), tbl[i].occ, tbl[i].ir, tbl[i].od, tbl[i].drops);
        end

        // fill to FULL, then prove in_ready has no combinational path from out_ready/flush
        drive(1'b1, 16'h0055, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 16'h0066, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_outs("full", 2'd2, 1'b0, 16'h0055, 2'd3);
        drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        #1;
        chk("ready_registered.in_ready", 32'(in_ready), 32'd0);
        chk("ready_registered.out_valid", 32'(out_valid), 32'd1);

        // async reset between edges clears everything, including drop count
        reset = 1'b1;
        #1;
        check_outs("async_reset", 2'd0, 1'b1, NOP, 2'd0);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 16'h00D0, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_outs("after_reset_D", 2'd1, 1'b1, 16'h00D0, 2'd0);
        drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_outs("after_reset_pop", 2'd0, 1'b1, NOP, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
